// File: rtl/uart_pkg.sv
// Shared state encoding and default frame constants for the UART receiver.
package uart_pkg;

  localparam int DBIT_DEFAULT    = 8;
  localparam int SB_TICK_DEFAULT = 16;
  localparam int OVERSAMPLE      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 1 (idle line).
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit centring, DBIT data bits LSB first,
// configurable stop interval, registered word / frame error / done pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEFAULT,
  parameter int SB_TICK = SB_TICK_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
);

  localparam int          NW       = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [4:0]  S_MID    = 5'(OVERSAMPLE / 2 - 1);
  localparam logic [4:0]  S_BIT    = 5'(OVERSAMPLE - 1);
  localparam logic [4:0]  S_STOP   = 5'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  state_t          state, state_next;
  logic [4:0]      s, s_next;
  logic [NW-1:0]   n, n_next;
  logic [DBIT-1:0] b, b_next;
  logic            rx_s;
  logic            done_set;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      dout         <= '0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      state        <= state_next;
      s            <= s_next;
      n            <= n_next;
      b            <= b_next;
      rx_done_tick <= done_set;
      if (done_set) begin
        dout      <= b;
        frame_err <= ~rx_s;
      end
    end
  end

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    b_next     = b;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == S_MID) begin
            // A start bit that is high again at its centre was a glitch.
            if (!rx_s) begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == S_BIT) begin
            s_next = '0;
            b_next = {rx_s, b[DBIT-1:1]};
            if (n == N_LAST) state_next = STOP;
            else             n_next     = n + 1'b1;
          end else begin
            s_next = s + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == S_STOP) state_next = IDLE;
          else             s_next     = s + 5'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    done_set = (state == STOP) && s_tick && (s == S_STOP);
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: default 8N1 instance plus a 7-bit, 2-stop instance.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic [7:0] dout_a;
  logic [6:0] dout_b;
  logic       rx_done_tick_a, rx_done_tick_b;
  logic       frame_err_a, frame_err_b;

  int tcnt = 0;
  int tick_idx = 0;
  int pulses_a = 0;
  int pulses_b = 0;
  int done_a_idx = 0;
  int done_b_idx = 0;
  int checks = 0;
  int errors = 0;
  int start_idx;

  uart_rx u_dut_a (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx_a),
    .s_tick       (s_tick),
    .dout         (dout_a),
    .rx_done_tick (rx_done_tick_a),
    .frame_err    (frame_err_a)
  );

  uart_rx #(.DBIT(7), .SB_TICK(32)) u_dut_b (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx_b),
    .s_tick       (s_tick),
    .dout         (dout_b),
    .rx_done_tick (rx_done_tick_b),
    .frame_err    (frame_err_b)
  );

  always #5 clk = ~clk;

  // One-clk s_tick every 10 clks; tick_idx counts ticks consumed by the DUTs.
  always @(posedge clk) begin
    if (tcnt == 9) begin
      tcnt   <= 0;
      s_tick <= 1'b1;
    end else begin
      tcnt   <= tcnt + 1;
      s_tick <= 1'b0;
    end
    if (s_tick) tick_idx <= tick_idx + 1;
  end

  always @(negedge clk) begin
    if (rx_done_tick_a) begin
      pulses_a   = pulses_a + 1;
      done_a_idx = tick_idx;
    end
    if (rx_done_tick_b) begin
      pulses_b   = pulses_b + 1;
      done_b_idx = tick_idx;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge inside the k-th upcoming s_tick cycle (not yet consumed).
  task automatic wait_ticks(input int k);
    repeat (k) begin
      do @(negedge clk); while (!s_tick);
    end
  endtask

  task automatic drive(input bit sel_b, input logic v);
    if (sel_b) rx_b = v;
    else       rx_a = v;
  endtask

  // Each bit held 16 ticks; stop level is released to idle after its centre sample.
  task automatic send_frame(input bit sel_b, input logic [7:0] data, input int nbits,
                            input logic stop_val, input int stop_ticks);
    drive(sel_b, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < nbits; i++) begin
      drive(sel_b, data[i]);
      wait_ticks(16);
    end
    drive(sel_b, stop_val);
    wait_ticks(10);
    drive(sel_b, 1'b1);
    wait_ticks(stop_ticks - 10);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_dout_a", {24'b0, dout_a}, 32'h0);
    check("reset_ferr_a", {31'b0, frame_err_a}, 32'h0);
    check("reset_done_a", {31'b0, rx_done_tick_a}, 32'h0);
    check("reset_dout_b", {25'b0, dout_b}, 32'h0);
    reset = 1'b0;
    wait_ticks(4);

    // 0x55, one stop bit
    start_idx = tick_idx;
    send_frame(1'b0, 8'h55, 8, 1'b1, 16);
    check("f55_pulses", pulses_a, 1);
    check("f55_dout", {24'b0, dout_a}, 32'h55);
    check("f55_ferr", {31'b0, frame_err_a}, 32'h0);
    check("f55_done_tick", done_a_idx, start_idx + 153);

    // start glitch: low for 4 ticks
    rx_a = 1'b0;
    wait_ticks(4);
    rx_a = 1'b1;
    wait_ticks(16);
    check("glitch_pulses", pulses_a, 1);
    check("glitch_dout", {24'b0, dout_a}, 32'h55);

    // 0xA3 with stop bit low
    send_frame(1'b0, 8'hA3, 8, 1'b0, 16);
    check("fA3_pulses", pulses_a, 2);
    check("fA3_dout", {24'b0, dout_a}, 32'hA3);
    check("fA3_ferr", {31'b0, frame_err_a}, 32'h1);
    wait_ticks(16);
    check("fA3_after_pulses", pulses_a, 2);
    check("fA3_after_dout", {24'b0, dout_a}, 32'hA3);

    // back-to-back 0x0F, 0xF0
    send_frame(1'b0, 8'h0F, 8, 1'b1, 16);
    check("f0F_pulses", pulses_a, 3);
    check("f0F_dout", {24'b0, dout_a}, 32'h0F);
    check("f0F_ferr", {31'b0, frame_err_a}, 32'h0);
    send_frame(1'b0, 8'hF0, 8, 1'b1, 16);
    check("fF0_pulses", pulses_a, 4);
    check("fF0_dout", {24'b0, dout_a}, 32'hF0);
    check("fF0_ferr", {31'b0, frame_err_a}, 32'h0);

    // 7 data bits, 2 stop bits on instance b
    wait_ticks(4);
    start_idx = tick_idx;
    send_frame(1'b1, 8'h5A, 7, 1'b1, 32);
    check("b5A_pulses", pulses_b, 1);
    check("b5A_dout", {25'b0, dout_b}, 32'h5A);
    check("b5A_ferr", {31'b0, frame_err_b}, 32'h0);
    check("b5A_stop_latency", done_b_idx - (start_idx + 121), 32);

    // reset during data bit 4 of 0x3C
    wait_ticks(4);
    rx_a = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx_a = (8'h3C >> i) & 8'h01;
      wait_ticks(16);
    end
    rx_a = 1'b1;
    wait_ticks(8);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    rx_a = 1'b1;
    reset = 1'b0;
    wait_ticks(20);
    check("rst_pulses", pulses_a, 4);
    check("rst_dout", {24'b0, dout_a}, 32'h0);
    check("rst_dout_b", {25'b0, dout_b}, 32'h0);
    send_frame(1'b0, 8'h81, 8, 1'b1, 16);
    check("f81_pulses", pulses_a, 5);
    check("f81_dout", {24'b0, dout_a}, 32'h81);
    check("f81_ferr", {31'b0, frame_err_a}, 32'h0);

    // break: line low for two full frames, released mid third start bit
    rx_a = 1'b0;
    wait_ticks(310);
    rx_a = 1'b1;
    wait_ticks(20);
    check("brk_pulses", pulses_a, 7);
    check("brk_dout", {24'b0, dout_a}, 32'h0);
    check("brk_ferr", {31'b0, frame_err_a}, 32'h1);
    check("brk_pulses_b", pulses_b, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
